// File: rtl/bulk_in_xfer_reader.sv
// Bulk IN endpoint reader: buffers one packet from the endpoint FIFO and
// replays it to the transmitter until the host ACKs, with DATA0/1 and ZLP.
module bulk_in_xfer_reader #(
    parameter int MAX_PACKET = 512
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tok_in_i,
    input  logic       ack_i,
    input  logic       timeout_i,
    input  logic       clr_toggle_i,
    input  logic       ep_has_data_i,
    output logic       ep_xfer_o,
    input  logic       ep_tvalid_i,
    output logic       ep_tready_o,
    input  logic       ep_tlast_i,
    input  logic [7:0] ep_tdata_i,
    output logic       tx_tvalid_o,
    input  logic       tx_tready_i,
    output logic       tx_tlast_o,
    output logic [7:0] tx_tdata_o,
    output logic       tx_pid_o,
    output logic       tx_zlp_o,
    output logic       tx_nak_o,
    output logic       busy_o
);

    localparam int AW = $clog2(MAX_PACKET);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        EMPTY,
        FILL,
        READY,
        SEND,
        WAIT_ACK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   len;
    logic [LW-1:0]   rd_ptr;
    logic            zlp_pend;
    logic            toggle;
    logic            tvalid_q;
    logic            tlast_q;
    logic            nak_q;
    logic            zlp_q;
    logic [7:0]      mem [MAX_PACKET];
    logic [7:0]      rd_q;
    logic [AW-1:0]   ram_addr;
    logic            wr_en;
    logic            rd_en;
    logic            tx_fire;
    logic            fill_full;
    logic            ack_hit;
    logic            tok_ready;

    assign wr_en     = (state == FILL) && ep_tvalid_i;
    assign fill_full = (len == LW'(MAX_PACKET - 1));
    assign tx_fire   = tvalid_q && tx_tready_i;
    assign rd_en     = (state == SEND) && (rd_ptr < len)
                       && (!tvalid_q || tx_tready_i);
    assign ack_hit   = (state == WAIT_ACK) && ack_i;
    assign tok_ready = (state == READY) && tok_in_i;
    assign ram_addr  = wr_en ? len[AW-1:0] : rd_ptr[AW-1:0];

    // Single-port buffer: writes only happen in FILL, reads only in SEND.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ram_addr] <= ep_tdata_i;
        else if (rd_en)
            rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:
                if (ep_has_data_i)
                    state_nxt = FILL;
            FILL:
                if (wr_en && (ep_tlast_i || fill_full))
                    state_nxt = READY;
                else if (!ep_has_data_i && !ep_tvalid_i && len != '0)
                    state_nxt = READY;
            READY:
                if (tok_in_i)
                    state_nxt = (len == '0) ? WAIT_ACK : SEND;
            SEND:
                if (tx_fire && tlast_q)
                    state_nxt = WAIT_ACK;
            WAIT_ACK:
                if (ack_i)
                    state_nxt = zlp_pend ? READY : EMPTY;
                else if (timeout_i)
                    state_nxt = READY;
            default:
                state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        ep_xfer_o   = (state == FILL);
        ep_tready_o = (state == FILL);
        busy_o      = (state != EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len      <= '0;
            zlp_pend <= 1'b0;
            toggle   <= 1'b0;
            rd_ptr   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            nak_q    <= 1'b0;
            zlp_q    <= 1'b0;
        end else begin
            if (wr_en)
                len <= len + LW'(1);
            else if (ack_hit)
                len <= '0;

            if (wr_en && ep_tlast_i && fill_full)
                zlp_pend <= 1'b1;
            else if (ack_hit)
                zlp_pend <= 1'b0;

            // A toggle clear beats the ACK flip in the same cycle.
            if (clr_toggle_i)
                toggle <= 1'b0;
            else if (ack_hit)
                toggle <= ~toggle;

            if (tok_ready)
                rd_ptr <= '0;
            else if (rd_en)
                rd_ptr <= rd_ptr + LW'(1);

            if (rd_en) begin
                tvalid_q <= 1'b1;
                tlast_q  <= (rd_ptr == len - LW'(1));
            end else if (tx_fire) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            nak_q <= tok_in_i && (state == EMPTY || state == FILL);
            zlp_q <= tok_ready && (len == '0);
        end
    end

    assign tx_tvalid_o = tvalid_q;
    assign tx_tlast_o  = tvalid_q && tlast_q;
    assign tx_tdata_o  = tvalid_q ? rd_q : 8'h00;
    assign tx_pid_o    = toggle;
    assign tx_zlp_o    = zlp_q;
    assign tx_nak_o    = nak_q;

endmodule

// File: doc/bulk_in_xfer_reader.md
# bulk_in_xfer_reader

Protocol-side reader for a bulk IN endpoint FIFO. It prefetches one USB packet (up to MAX_PACKET bytes) from the endpoint's AXIS-style output into a local packet buffer. It answers host IN tokens with either DATA or NAK, and retains the packet until the host ACKs it, so a timed-out packet is retransmitted byte-exact. It sits between the bulk IN endpoint FIFO and the USB packet transmitter, in the `usb_clk` domain, and also owns the DATA0/DATA1 toggle and zero-length-packet (ZLP) termination.

## Interface
- MAX_PACKET, 512: max bytes per data packet; power of two, 8..1024.
- clk  in  1  USB clock (60 MHz ULPI-derived).
- reset_n  in  1  asynchronous, active-low reset.
- tok_in_i  in  1  1-cycle pulse: host IN token addressed to this endpoint.
- ack_i  in  1  1-cycle pulse: host ACK received for the last DATA packet.
- timeout_i  in  1  1-cycle pulse: no handshake received within turnaround time.
- clr_toggle_i  in  1  1-cycle pulse: reset data toggle to DATA0 (SET_CONFIGURATION / CLEAR_FEATURE).
- ep_has_data_i  in  1  endpoint FIFO holds at least one byte.
- ep_xfer_o  out  1  high while draining the endpoint FIFO.
- ep_tvalid_i  in  1  endpoint byte valid.
- ep_tready_o  out  1  endpoint byte accepted.
- ep_tlast_i  in  1  last byte of an AXIS frame.
- ep_tdata_i  in  8  endpoint byte.
- tx_tvalid_o  out  1  DATA payload byte valid to transmitter.
- tx_tready_i  in  1  transmitter accepts byte.
- tx_tlast_o  out  1  last payload byte.
- tx_tdata_o  out  8  payload byte.
- tx_pid_o  out  1  data PID for current packet: 0 = DATA0, 1 = DATA1.
- tx_zlp_o  out  1  1-cycle pulse: send zero-length DATA packet.
- tx_nak_o  out  1  1-cycle pulse: send NAK handshake.
- busy_o  out  1  packet buffer holds an unacknowledged or partially filled packet.

## Operation
- **States**
  - EMPTY: no packet buffered.
  - FILL: reading from the endpoint.
  - READY: packet buffered, awaiting a token.
  - SEND: streaming the packet to the transmitter.
  - WAIT_ACK: waiting for the host handshake.
- **EMPTY -> FILL** when `ep_has_data_i`=1.
  - `ep_xfer_o` = `ep_tready_o` = 1 throughout FILL.
  - Bytes are written to the buffer at `len`, and `len` increments per accepted byte.
- **FILL -> READY** when one of these occurs:
  - A byte with `ep_tlast_i` is accepted.
  - `len` reaches MAX_PACKET.
  - `ep_has_data_i`=0 with `ep_tvalid_i`=0 and `len`>0. This is a short packet without tlast.
- **ZLP pending:** if `len`=MAX_PACKET and the final byte carried tlast, set `zlp_pend`.
- **READY + tok_in_i -> SEND.** Replay from buffer address 0 through `len`-1. `tx_tlast_o` is set on byte `len`-1.
  - If `len`=0 (ZLP), pulse `tx_zlp_o` and go directly to WAIT_ACK.
- **SEND -> WAIT_ACK** after the last byte handshake.
- **WAIT_ACK + ack_i:**
  - Flip the toggle.
  - If `zlp_pend`: clear it, set `len`=0, go to READY.
  - Otherwise: `len`=0, go to EMPTY.
- **WAIT_ACK + timeout_i -> READY.** Buffer and toggle are unchanged (retry).
- **NAK:** `tok_in_i` in EMPTY or FILL pulses `tx_nak_o` on the next cycle. FILL continues uninterrupted.
- **Ignored events:**
  - `tok_in_i` in SEND or WAIT_ACK.
  - `ack_i` / `timeout_i` outside WAIT_ACK.
- **Toggle:** `clr_toggle_i` forces the toggle to 0 in any state. It wins over a simultaneous `ack_i` flip.
- **Simultaneous handshakes:** `ack_i` and `timeout_i` in the same cycle are treated as ACK.
- **busy_o** = state ≠ EMPTY.
- **Widths:** `len` is clog2(MAX_PACKET)+1 bits. The buffer is MAX_PACKET x 8, single-port, inferred block RAM.

## Timing
- **Reset values:** all outputs 0; state EMPTY; toggle 0; `len` 0; `zlp_pend` 0. Buffer contents are don't-care.
- **Reset mid-operation:** any packet in flight is discarded. No NAK or ZLP is emitted after reset.
- **Fill:** `ep_xfer_o` rises 1 cycle after `ep_has_data_i` is sampled high in EMPTY. Fill runs at 1 byte per cycle while `ep_tvalid_i`=1.
- **Send:**
  - `tx_tvalid_o` first asserts 2 cycles after `tok_in_i` is sampled in READY (one cycle of registered RAM read).
  - Thereafter 1 byte per cycle while `tx_tready_i`=1.
  - While `tx_tready_i`=0, `tx_tdata_o`, `tx_tlast_o` and `tx_tvalid_o` hold stable.
- **PID:** `tx_pid_o` is stable from SEND entry until the ACK/timeout decision, and updates 1 cycle after `ack_i`.
- **Pulses:** `tx_nak_o` and `tx_zlp_o` are exactly 1 cycle wide, registered, asserted 1 cycle after `tok_in_i`.

## Test plan
- **Short packet:** write a 5-byte AXIS frame (tlast on byte 5), then `tok_in_i`.
  - Expect 5 bytes out, tlast on byte 5, `tx_pid_o`=0.
  - After `ack_i`: EMPTY, toggle=1.
- **Retransmit:** 12-byte packet sent, then `timeout_i`, then `tok_in_i`.
  - Expect the identical 12 bytes and `tx_pid_o`=0 again.
  - `ack_i` then flips `tx_pid_o` to 1.
- **Exact-multiple frame:** 1024-byte frame with tlast on byte 1024, MAX_PACKET=512.
  - Expect two 512-byte packets (PID 0, then 1).
  - Then on the third token: `tx_zlp_o` pulse with PID 0.
- **NAK cases:** `tok_in_i` with FIFO empty -> `tx_nak_o` pulse, state stays EMPTY. `tok_in_i` during FILL -> NAK, fill completes.
- **Backpressure:** toggle `tx_tready_i` 1,0,0,1 during a 4-byte send.
  - No byte dropped or duplicated.
  - Data is stable while stalled.
- **Toggle priority and reset:**
  - `clr_toggle_i` with `ack_i` in the same cycle -> toggle=0.
  - Assert `reset_n`=0 mid-SEND -> all outputs 0, state EMPTY, no stray pulses after release.
